// File: rtl/float_to_fixed_conv.sv
// ============================================================================
// Module      : float_to_fixed_conv
// Description : Iterative IEEE-754 single to signed Q(OUT_W-FRAC_BITS).FRAC_BITS
//               converter with saturation and NaN/Inf/denormal classification.
//               Define F2X_ROUND_NEAREST_EN for round-half-to-even (else truncate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_to_fixed_conv #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_a,
    input  logic             in_stb,
    output logic             in_ack,
    output logic [OUT_W-1:0] out_z,
    output logic             out_stb,
    input  logic             out_ack,
    output logic             out_ovf,
    output logic             out_nan
);

    // Magnitude needs OUT_W+1 bits for the rounding carry, and at least 25 so
    // the 24-bit mantissa fits before right shifts on narrow outputs.
    localparam int c_MAG_W = (OUT_W + 1 > 25) ? OUT_W + 1 : 25;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_UNPACK   = 3'd1;
    localparam logic [2:0] S_CLASSIFY = 3'd2;
    localparam logic [2:0] S_SHIFT    = 3'd3;
    localparam logic [2:0] S_ROUND    = 3'd4;
    localparam logic [2:0] S_OUTPUT   = 3'd5;

    localparam logic signed [10:0] c_K_SAT  = 11'(OUT_W - 23);
    localparam logic signed [10:0] c_K_ZERO = -11'sd25;
    localparam logic signed [10:0] c_FRAC_K = 11'(FRAC_BITS);

    localparam logic [OUT_W-1:0]   c_Z_POS    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   c_Z_NEG    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [c_MAG_W-1:0] c_POS_MAX  = {{(c_MAG_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [c_MAG_W-1:0] c_NEG_MAG  = {{(c_MAG_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    logic [2:0]             r_state;
    logic [2:0]             r_state_nxt;
    logic [31:0]            r_a;
    logic [23:0]            r_mant;
    logic signed [10:0]     r_k;
    logic [c_MAG_W-1:0]     r_mag;
    logic [6:0]             r_cnt;
    logic                   r_dir_left;
`ifdef F2X_ROUND_NEAREST_EN
    logic                   r_guard;
    logic                   r_sticky;
`endif
    logic                   r_in_ack;
    logic [OUT_W-1:0]       r_out_z;
    logic                   r_out_stb;
    logic                   r_out_ovf;
    logic                   r_out_nan;

    logic [7:0]             w_exp;
    logic [22:0]            w_frac;
    logic [6:0]             w_k_abs;
    logic                   w_cls_done;
    logic [OUT_W-1:0]       w_cls_z;
    logic                   w_cls_ovf;
    logic                   w_cls_nan;
    logic                   w_inc;
    logic [c_MAG_W-1:0]     w_mag_rnd;
    logic [OUT_W-1:0]       w_mag_lo;
    logic [OUT_W-1:0]       w_rnd_z;
    logic                   w_rnd_ovf;
    logic                   w_in_ack_nxt;
    logic                   w_out_stb_nxt;
    logic                   w_load_out;
    logic [OUT_W-1:0]       w_z_nxt;
    logic                   w_ovf_nxt;
    logic                   w_nan_nxt;

    assign w_exp   = r_a[30:23];
    assign w_frac  = r_a[22:0];
    assign w_k_abs = r_k[10] ? (7'd0 - r_k[6:0]) : r_k[6:0];

    always_comb begin
        w_cls_done = 1'b1;
        w_cls_z    = '0;
        w_cls_ovf  = 1'b0;
        w_cls_nan  = 1'b0;
        if (w_exp == 8'hFF && w_frac != 23'd0) begin
            w_cls_nan = 1'b1;
        end else if (w_exp == 8'hFF || r_k >= c_K_SAT) begin
            w_cls_ovf = 1'b1;
            w_cls_z   = r_a[31] ? c_Z_NEG : c_Z_POS;
        end else if (w_exp == 8'h00 || r_k <= c_K_ZERO) begin
            w_cls_z   = '0;
        end else begin
            w_cls_done = 1'b0;
        end
    end

`ifdef F2X_ROUND_NEAREST_EN
    assign w_inc = r_guard & (r_sticky | r_mag[0]);
`else
    assign w_inc = 1'b0;
`endif

    assign w_mag_rnd = r_mag + {{(c_MAG_W-1){1'b0}}, w_inc};
    assign w_mag_lo  = w_mag_rnd[OUT_W-1:0];

    always_comb begin
        w_rnd_ovf = 1'b0;
        w_rnd_z   = '0;
        if (!r_a[31]) begin
            if (w_mag_rnd > c_POS_MAX) begin
                w_rnd_ovf = 1'b1;
                w_rnd_z   = c_Z_POS;
            end else begin
                w_rnd_z   = w_mag_lo;
            end
        end else begin
            if (w_mag_rnd > c_NEG_MAG) begin
                w_rnd_ovf = 1'b1;
                w_rnd_z   = c_Z_NEG;
            end else begin
                w_rnd_z   = -w_mag_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (in_stb && r_in_ack) r_state_nxt = S_UNPACK;
            S_UNPACK:   r_state_nxt = S_CLASSIFY;
            S_CLASSIFY: r_state_nxt = w_cls_done ? S_OUTPUT : S_SHIFT;
            S_SHIFT:    if (r_cnt == 7'd0) r_state_nxt = S_ROUND;
            S_ROUND:    r_state_nxt = S_OUTPUT;
            S_OUTPUT:   if (r_out_stb && out_ack) r_state_nxt = S_IDLE;
            default:    r_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ack_nxt  = (r_state == S_IDLE) && !(in_stb && r_in_ack);
        w_out_stb_nxt = (r_state_nxt == S_OUTPUT);
        w_load_out    = (r_state == S_ROUND) || (r_state == S_CLASSIFY && w_cls_done);
        w_z_nxt       = (r_state == S_ROUND) ? w_rnd_z   : w_cls_z;
        w_ovf_nxt     = (r_state == S_ROUND) ? w_rnd_ovf : w_cls_ovf;
        w_nan_nxt     = (r_state == S_ROUND) ? 1'b0      : w_cls_nan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_mant     <= '0;
            r_k        <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
`ifdef F2X_ROUND_NEAREST_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
            r_in_ack   <= 1'b0;
            r_out_z    <= '0;
            r_out_stb  <= 1'b0;
            r_out_ovf  <= 1'b0;
            r_out_nan  <= 1'b0;
        end else begin
            r_in_ack  <= w_in_ack_nxt;
            r_out_stb <= w_out_stb_nxt;
            if (w_load_out) begin
                r_out_z   <= w_z_nxt;
                r_out_ovf <= w_ovf_nxt;
                r_out_nan <= w_nan_nxt;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_stb && r_in_ack) r_a <= in_a;
                end
                S_UNPACK: begin
                    r_mant <= {1'b1, r_a[22:0]};
                    r_k    <= $signed({3'b000, r_a[30:23]}) - 11'sd150 + c_FRAC_K;
                end
                S_CLASSIFY: begin
                    if (!w_cls_done) begin
                        r_mag      <= {{(c_MAG_W-24){1'b0}}, r_mant};
                        r_cnt      <= w_k_abs;
                        r_dir_left <= !r_k[10];
`ifdef F2X_ROUND_NEAREST_EN
                        r_guard    <= 1'b0;
                        r_sticky   <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != 7'd0) begin
                        r_cnt <= r_cnt - 7'd1;
                        if (r_dir_left) begin
                            r_mag <= r_mag << 1;
                        end else begin
`ifdef F2X_ROUND_NEAREST_EN
                            r_guard  <= r_mag[0];
                            r_sticky <= r_sticky | r_guard;
`endif
                            r_mag    <= r_mag >> 1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ack  = r_in_ack;
    assign out_z   = r_out_z;
    assign out_stb = r_out_stb;
    assign out_ovf = r_out_ovf;
    assign out_nan = r_out_nan;

endmodule

`default_nettype wire

// File: tb/tb_float_to_fixed_conv.sv
// ============================================================================
// Module      : tb_float_to_fixed_conv
// Description : Scoreboard bench for float_to_fixed_conv (OUT_W=32, FRAC_BITS=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_to_fixed_conv;

    localparam int c_W = 32;
    localparam int c_F = 16;

    typedef struct {
        logic [31:0] z;
        logic        ovf;
        logic        nan;
        int          lat;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [31:0]     in_a;
    logic            in_stb;
    logic            in_ack;
    logic [c_W-1:0]  out_z;
    logic            out_stb;
    logic            out_ack;
    logic            out_ovf;
    logic            out_nan;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    float_to_fixed_conv #(.OUT_W(c_W), .FRAC_BITS(c_F)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .in_a    (in_a),
        .in_stb  (in_stb),
        .in_ack  (in_ack),
        .out_z   (out_z),
        .out_stb (out_stb),
        .out_ack (out_ack),
        .out_ovf (out_ovf),
        .out_nan (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Arithmetic reference: whole-shift with remainder-based rounding.
    function automatic exp_t model(input logic [31:0] a);
        exp_t r;
        int ex;
        int k;
        logic neg;
        longint unsigned mant, mag, rem, half, tmp;
        r.z = '0; r.ovf = 1'b0; r.nan = 1'b0; r.lat = 3;
        ex   = int'(a[30:23]);
        neg  = a[31];
        mant = 64'(a[22:0]) | 64'h80_0000;
        k    = ex - 150 + c_F;
        if (ex == 255 && a[22:0] != 23'd0) begin
            r.nan = 1'b1;
        end else if (ex == 255 || 23 + k >= c_W) begin
            r.ovf = 1'b1;
            r.z   = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (ex == 0 || k <= -25) begin
            r.z = '0;
        end else begin
            r.lat = ((k < 0) ? -k : k) + 5;
            if (k >= 0) begin
                mag = mant << k;
            end else begin
                mag  = mant >> (-k);
                rem  = mant & ((64'd1 << (-k)) - 64'd1);
                half = 64'd1 << (-k - 1);
`ifdef F2X_ROUND_NEAREST_EN
                if (rem > half || (rem == half && mag[0])) mag = mag + 64'd1;
`else
                if (rem > half && half == 64'd0) mag = mag + 64'd1;
`endif
            end
            if (!neg && mag > 64'h7FFF_FFFF) begin
                r.ovf = 1'b1;
                r.z   = 32'h7FFF_FFFF;
            end else if (neg && mag > 64'h8000_0000) begin
                r.ovf = 1'b1;
                r.z   = 32'h8000_0000;
            end else begin
                tmp = neg ? (64'd0 - mag) : mag;
                r.z = tmp[31:0];
            end
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input int hold);
        exp_t e;
        int   t;
        int   lat;
        sb.push_back(model(a));
        @(negedge clk);
        in_a   = a;
        in_stb = 1'b1;
        t = 0;
        while (!in_ack && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("in_ack_ready", 64'(in_ack), 64'd1);
        @(posedge clk);
        #1;
        in_stb = 1'b0;
        in_a   = $urandom();
        lat    = 1;
        while (!out_stb && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check_eq("latency", 64'(lat), 64'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_z", 64'(out_z), 64'(e.z));
            check_eq("hold_stb", 64'(out_stb), 64'd1);
            check_eq("hold_in_ack", 64'(in_ack), 64'd0);
        end
        check_eq("out_z", 64'(out_z), 64'(e.z));
        check_eq("out_ovf", 64'(out_ovf), 64'(e.ovf));
        check_eq("out_nan", 64'(out_nan), 64'(e.nan));
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check_eq("stb_drop", 64'(out_stb), 64'd0);
        check_eq("in_ack_after_xfer", 64'(in_ack), 64'd0);
        @(posedge clk);
        #1;
        check_eq("in_ack_reopen", 64'(in_ack), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] dir [12];
        logic [31:0] ra;
        int t;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_a     = '0;
        in_stb   = 1'b0;
        out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ack", 64'(in_ack), 64'd0);
        check_eq("rst_out_stb", 64'(out_stb), 64'd0);
        check_eq("rst_out_z", 64'(out_z), 64'd0);
        check_eq("rst_ovf_nan", 64'({out_ovf, out_nan}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h3FC0_0000, 10);   // 1.5 with back-pressure

        dir = '{32'hC010_0000, 32'h4788_B800, 32'h7FC0_0000, 32'h37C0_0000,
                32'h0000_0000, 32'h0000_0001, 32'hC700_0000, 32'h4700_0000,
                32'h3680_0000, 32'h3700_0000, 32'h3780_0001, 32'hFF80_0000};
        foreach (dir[i]) run_op(dir[i], 0);

        // Reset in the middle of a SHIFT sequence; previous op left ovf=1.
        @(negedge clk);
        in_a   = 32'h3FC0_0000;
        in_stb = 1'b1;
        t = 0;
        while (!in_ack && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        in_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_in_ack", 64'(in_ack), 64'd0);
        check_eq("mid_rst_out_stb", 64'(out_stb), 64'd0);
        check_eq("mid_rst_out_z", 64'(out_z), 64'd0);
        check_eq("mid_rst_ovf", 64'(out_ovf), 64'd0);
        check_eq("mid_rst_nan", 64'(out_nan), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hC010_0000, 0);

        for (int i = 0; i < 16; i++) begin
            ra = {1'($urandom_range(1, 0)), 8'($urandom_range(160, 100)), 23'($urandom())};
            run_op(ra, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
